// File: rtl/flag_unit_if.sv
// flag_unit_if: bundles the flag unit's control inputs and status outputs.
//   master: drives alu_flag/update/mask/push/pop/err_clr, observes status.
//   slave : the flag unit itself; returns flag/level/full/empty/err.
interface flag_unit_if;
  logic [3:0] alu_flag;  // N/Z/C/V from the ALU
  logic       update;
  logic [3:0] mask;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [3:0] flag;      // registered N/Z/C/V
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic       err;

  modport master (
    output alu_flag, update, mask, push, pop, err_clr,
    input  flag, level, full, empty, err
  );

  modport slave (
    input  alu_flag, update, mask, push, pop, err_clr,
    output flag, level, full, empty, err
  );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: N/Z/C/V condition flag register with a DEPTH-entry save stack
// for call/interrupt entry and return, plus a sticky misuse indicator.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - flag_unit_if.slave (masked update, push/pop, err clear, status)
module flag_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  flag_unit_if.slave  bus
);

  localparam int unsigned FW = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FW-1:0] stack [DEPTH];
  logic [FW-1:0] flag_q, flag_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;

  logic full_c, empty_c;
  logic push_ok, pop_ok, misuse;
  logic [FW-1:0] updated_flag;

  assign full_c  = (level_q == LW'(DEPTH));
  assign empty_c = (level_q == '0);

  // Classify the stack request for this cycle.
  always_comb begin
    push_ok = bus.push & ~bus.pop & ~full_c;
    pop_ok  = bus.pop & ~bus.push & ~empty_c;
    misuse  = (bus.push & bus.pop)
            | (bus.push & ~bus.pop & full_c)
            | (bus.pop & ~bus.push & empty_c);
  end

  // Next-state for flag, level and sticky error.
  always_comb begin
    updated_flag = (flag_q & ~bus.mask) | (bus.alu_flag & bus.mask);
    flag_d       = flag_q;
    level_d      = level_q;
    err_d        = err_q;

    if (pop_ok) begin
      // A valid restore wins over any same-cycle update.
      flag_d  = stack[AW'(level_q - LW'(1))];
      level_d = level_q - LW'(1);
    end else if (bus.update && !(bus.push && bus.pop)) begin
      flag_d = updated_flag;
    end

    if (push_ok) begin
      level_d = level_q + LW'(1);
    end

    // New misuse dominates a same-cycle clear.
    if (misuse) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q  <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; level gates all reads.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      stack[AW'(level_q)] <= flag_q;
    end
  end

  assign bus.flag  = flag_q;
  assign bus.level = level_q;
  assign bus.full  = full_c;
  assign bus.empty = empty_c;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed bench for flag_unit with a queue-based reference
// model checked every cycle plus hand-computed literal expectations.
module tb_flag_unit;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;
  flag_unit_if bus ();

  flag_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [3:0] flag_m;
  logic [3:0] q_m [$];
  logic       err_m;
  bit         check_en = 1'b0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit upd, input logic [3:0] m,
                            input logic [3:0] a, input bit ps, input bit pp,
                            input bit ec);
    bit bad;
    bad = 1'b0;
    if (rst) begin
      flag_m = 4'h0;
      q_m.delete();
      err_m  = 1'b0;
    end else begin
      if (ps && pp) begin
        bad = 1'b1;
      end else if (pp) begin
        if (q_m.size() == 0) begin
          bad = 1'b1;
          if (upd) flag_m = (flag_m & ~m) | (a & m);
        end else begin
          flag_m = q_m.pop_back();
        end
      end else begin
        if (ps) begin
          if (q_m.size() == DEPTH) bad = 1'b1;
          else q_m.push_back(flag_m);
        end
        if (upd) flag_m = (flag_m & ~m) | (a & m);
      end
      if (bad) err_m = 1'b1;
      else if (ec) err_m = 1'b0;
    end
  endtask

  // Drive one cycle, advance past the edge and step the model.
  task automatic step(input bit rst, input bit upd, input logic [3:0] m,
                      input logic [3:0] a, input bit ps, input bit pp,
                      input bit ec);
    reset        = rst;
    bus.update   = upd;
    bus.mask     = m;
    bus.alu_flag = a;
    bus.push     = ps;
    bus.pop      = pp;
    bus.err_clr  = ec;
    @(posedge clk);
    #1;
    model_edge(rst, upd, m, a, ps, pp, ec);
    check_en = 1'b1;
  endtask

  // Compare DUT against the model every cycle once reset has been applied.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_flag",  bus.flag,  flag_m);
      chk("model_level", bus.level, 4'(q_m.size()));
      chk("model_full",  {3'b0, bus.full},  {3'b0, q_m.size() == DEPTH});
      chk("model_empty", {3'b0, bus.empty}, {3'b0, q_m.size() == 0});
      chk("model_err",   {3'b0, bus.err},   {3'b0, err_m});
    end
  end

  initial begin
    flag_m = 4'h0;
    err_m  = 1'b0;
    reset = 1'b0; bus.update = 1'b0; bus.mask = 4'h0; bus.alu_flag = 4'h0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    @(negedge clk);

    // Reset overrides other inputs.
    step(1, 1, 4'hF, 4'hF, 1, 0, 0);
    chk("rst_flag",  bus.flag, 4'h0);
    chk("rst_level", bus.level, 4'h0);
    chk("rst_empty", {3'b0, bus.empty}, 4'h1);
    chk("rst_full",  {3'b0, bus.full}, 4'h0);
    chk("rst_err",   {3'b0, bus.err}, 4'h0);

    // Full-mask and partial-mask updates.
    step(0, 1, 4'hF, 4'b0100, 0, 0, 0);
    chk("upd_all_flag", bus.flag, 4'b0100);
    chk("upd_all_level", bus.level, 4'h0);
    step(0, 1, 4'b1000, 4'b1011, 0, 0, 0);
    chk("upd_mask_flag", bus.flag, 4'b1100);
    step(0, 0, 4'hF, 4'hF, 0, 0, 0);
    chk("hold_flag", bus.flag, 4'b1100);

    // Push with update saves pre-update value.
    step(0, 1, 4'hF, 4'b1000, 0, 0, 0);
    step(0, 1, 4'hF, 4'b0010, 1, 0, 0);
    chk("pushupd_flag", bus.flag, 4'b0010);
    chk("pushupd_level", bus.level, 4'h1);
    step(0, 0, 4'h0, 4'h0, 0, 1, 0);
    chk("pop_flag", bus.flag, 4'b1000);
    chk("pop_level", bus.level, 4'h0);

    // Fill, overflow, drain in LIFO order.
    step(0, 1, 4'hF, 4'h1, 0, 0, 0);
    step(0, 1, 4'hF, 4'h2, 1, 0, 0);
    step(0, 1, 4'hF, 4'h3, 1, 0, 0);
    step(0, 1, 4'hF, 4'h4, 1, 0, 0);
    step(0, 0, 4'h0, 4'h0, 1, 0, 0);
    chk("fill_full", {3'b0, bus.full}, 4'h1);
    chk("fill_level", bus.level, 4'h4);
    step(0, 1, 4'hF, 4'h5, 1, 0, 0);
    chk("ovf_level", bus.level, 4'h4);
    chk("ovf_err", {3'b0, bus.err}, 4'h1);
    chk("ovf_upd", bus.flag, 4'h5);
    step(0, 0, 4'h0, 4'h0, 0, 1, 0);
    chk("drain0", bus.flag, 4'h4);
    step(0, 1, 4'hF, 4'hF, 0, 1, 0);
    chk("drain1_updignored", bus.flag, 4'h3);
    step(0, 0, 4'h0, 4'h0, 0, 1, 0);
    chk("drain2", bus.flag, 4'h2);
    step(0, 0, 4'h0, 4'h0, 0, 1, 0);
    chk("drain3", bus.flag, 4'h1);
    chk("drain_empty", {3'b0, bus.empty}, 4'h1);

    // Underflow, clear, push+pop misuse, clear vs misuse priority.
    step(0, 0, 4'h0, 4'h0, 0, 0, 1);
    chk("clr_err", {3'b0, bus.err}, 4'h0);
    step(0, 1, 4'b0001, 4'b0000, 0, 1, 0);
    chk("unf_err", {3'b0, bus.err}, 4'h1);
    chk("unf_upd", bus.flag, 4'h0);
    chk("unf_level", bus.level, 4'h0);
    step(0, 0, 4'h0, 4'h0, 0, 0, 1);
    step(0, 1, 4'hF, 4'h6, 0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 1, 0, 0);
    step(0, 1, 4'hF, 4'hF, 1, 1, 0);
    chk("pp_err", {3'b0, bus.err}, 4'h1);
    chk("pp_level", bus.level, 4'h1);
    chk("pp_flag", bus.flag, 4'h6);
    step(0, 0, 4'h0, 4'h0, 1, 1, 1);
    chk("clr_vs_misuse", {3'b0, bus.err}, 4'h1);
    step(0, 0, 4'h0, 4'h0, 0, 0, 1);
    chk("clr_err2", {3'b0, bus.err}, 4'h0);
    step(0, 0, 4'h0, 4'h0, 0, 1, 0);
    chk("pop_after_pp", bus.flag, 4'h6);

    // Reset mid-sequence discards saved entries.
    step(0, 1, 4'hF, 4'h9, 0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 1, 0, 0);
    step(0, 0, 4'h0, 4'h0, 1, 0, 0);
    chk("pre_rst_level", bus.level, 4'h2);
    step(1, 0, 4'h0, 4'h0, 0, 0, 0);
    chk("mid_rst_level", bus.level, 4'h0);
    chk("mid_rst_flag", bus.flag, 4'h0);
    step(0, 0, 4'h0, 4'h0, 0, 1, 0);
    chk("post_rst_pop_err", {3'b0, bus.err}, 4'h1);
    chk("post_rst_pop_flag", bus.flag, 4'h0);

    // Pseudo-random traffic, checked by the model each cycle.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter DEPTH, default 4: number of entries in the flag save stack; legal range 2..8.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 AluFlag  input  4  ALU result flags; bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-005 Update  input  1  load masked AluFlag bits into the flag register this cycle.
REQ-006 Mask  input  4  per-bit update enable; 1=bit loaded on Update, 0=bit held.
REQ-007 Push  input  1  save current Flag onto the stack (call/interrupt entry).
REQ-008 Pop  input  1  restore Flag from the top of the stack (return).
REQ-009 ErrClr  input  1  clear the sticky error flag.
REQ-010 Flag  output  4  registered flags, N/Z/C/V order as AluFlag; drives the condition checker directly.
REQ-011 Level  output  4  number of valid stack entries, 0..DEPTH.
REQ-012 Full  output  1  high when Level==DEPTH.
REQ-013 Empty  output  1  high when Level==0.
REQ-014 Err  output  1  sticky stack misuse indicator.

Function
REQ-015 All state SHALL update only on the rising edge of Clk; Flag, Level, Err SHALL be registered, Full/Empty SHALL be combinational decodes of Level.
REQ-016 Update with Pop=0 SHALL, at the next edge, set Flag[i]=AluFlag[i] where Mask[i]=1 and hold Flag[i] where Mask[i]=0; one-cycle latency.
REQ-017 Update=0 SHALL hold Flag unchanged unless a valid Pop occurs.
REQ-018 Push with Pop=0 and Full=0 SHALL write the pre-edge Flag value into entry Level and increment Level by 1.
REQ-019 Push and Update in the same cycle SHALL save the pre-update Flag and also apply the Update.
REQ-020 Pop with Push=0 and Empty=0 SHALL load Flag from entry Level-1, decrement Level by 1, and ignore Update that cycle.
REQ-021 Push with Full=1 (Pop=0) SHALL leave the stack and Level unchanged, set Err, and still apply any Update.
REQ-022 Pop with Empty=1 (Push=0) SHALL leave Flag and Level unchanged except for any Update, which SHALL apply, and set Err.
REQ-023 Push and Pop both high SHALL be treated as misuse: stack, Level and Flag held, Update ignored, Err set.
REQ-024 Err SHALL remain 1 once set until ErrClr is sampled high; ErrClr and a new misuse in the same cycle SHALL leave Err=1.
REQ-025 Stack entries not addressed by a Push SHALL never change; stale entries above Level SHALL not be observable on Flag.
REQ-026 Level SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-027 Reset high at an edge SHALL force Flag=4'b0000, Level=0, Err=0 (so Full=0, Empty=1), overriding all other inputs that cycle.
REQ-028 Stack entry contents need not be cleared by Reset; Level=0 makes them unreachable.
REQ-029 Reset asserted mid-sequence (non-empty stack) SHALL discard all saved entries; a subsequent Pop SHALL be an underflow.

Verification
REQ-030 Reset, then Update=1 Mask=4'b1111 AluFlag=4'b0100 -> next cycle Flag=4'b0100, Level=0, Empty=1.
REQ-031 Flag=4'b0100, Update=1 Mask=4'b1000 AluFlag=4'b1011 -> Flag=4'b1100.
REQ-032 Flag=4'b1000, Push+Update AluFlag=4'b0010 Mask=4'b1111 -> Flag=4'b0010, Level=1; then Pop -> Flag=4'b1000, Level=0.
REQ-033 DEPTH=4: push 4'h1,4'h2,4'h3,4'h4 -> Full=1; fifth Push -> Level=4, Err=1; four Pops return 4'h4,4'h3,4'h2,4'h1 in order.
REQ-034 Empty stack, Pop -> Err=1, Flag unchanged; ErrClr -> Err=0; Push+Pop same cycle -> Err=1, Level unchanged.
REQ-035 Level=2, Reset -> Level=0, Flag=4'b0000, Err=0; next Pop -> Err=1.
